inst_dispatch_ctrl: RTL and testbench

- Instruction queue and dispatch sequencer between fetch and the reservation stations / ROB of the Tomasulo core.
- Buffers fetched instructions and presents the queue head to the combinational decoder.
- Uses the decoder's fu/halt/illegal outputs to decide, each cycle, whether the head dispatches, stalls, is dropped, or halts the front end.
- Handles pipeline flush on branch mispredict.

---
 rtl/inst_dispatch_ctrl.sv | 118 +++++++++++
 tb/tb_inst_dispatch_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_dispatch_ctrl.sv
// Instruction queue and dispatch sequencer: buffers fetched instructions, presents
// the head to the decoder and dispatches, drops, stalls or halts based on its outputs.
module inst_dispatch_ctrl #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   fetch_valid,
  input  logic [31:0]            fetch_inst,
  input  logic [XLEN-1:0]        fetch_pc,
  output logic                   fetch_ready,
  output logic                   dec_valid,
  output logic [31:0]            dec_inst,
  output logic [XLEN-1:0]        dec_pc,
  input  logic [1:0]             dec_fu,
  input  logic                   dec_halt,
  input  logic                   dec_illegal,
  input  logic                   rob_ready,
  input  logic [3:0]             rs_ready,
  output logic                   dispatch_valid,
  output logic [1:0]             dispatch_fu,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t        q_mem [DEPTH];
  entry_t        head_e;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [0:0]    state;
  logic          run, push, pop, go_halt, drop;

  assign run         = (state == S_RUN);
  assign fetch_ready = run & (count < FULL) & ~flush;
  assign dec_valid   = run & (count != '0) & ~flush;
  assign push        = fetch_valid & fetch_ready;
  assign halted      = (state == S_HALT);
  assign occupancy   = count;

  // Head fields are zeroed when invalid so unwritten entries never leak X.
  assign head_e   = q_mem[head];
  assign dec_inst = dec_valid ? head_e.inst : '0;
  assign dec_pc   = dec_valid ? head_e.pc   : '0;

  always_comb begin
    pop            = 1'b0;
    drop           = 1'b0;
    go_halt        = 1'b0;
    dispatch_valid = 1'b0;
    if (dec_valid) begin
      if (dec_illegal) begin
        pop  = 1'b1;
        drop = 1'b1;
      end else if (dec_halt) begin
        if (rob_ready) begin
          pop            = 1'b1;
          dispatch_valid = 1'b1;
          go_halt        = 1'b1;
        end
      end else if (rob_ready & rs_ready[dec_fu]) begin
        pop            = 1'b1;
        dispatch_valid = 1'b1;
      end
    end
  end

  assign dispatch_fu = dispatch_valid ? dec_fu : 2'b00;

  always_ff @(posedge clock) begin
    if (push) q_mem[tail] <= '{inst: fetch_inst, pc: fetch_pc};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= S_RUN;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= S_RUN;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (go_halt) state <= S_HALT;
    end
  end

  // Survives flush; only reset clears the drop count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      illegal_cnt <= '0;
    else if (drop && illegal_cnt != 16'hFFFF)
      illegal_cnt <= illegal_cnt + 16'd1;
  end

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// Bench for inst_dispatch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based reference model and a small behavioural decoder.
module tb_inst_dispatch_ctrl;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] ADD  = 32'h002081b3;
  localparam logic [31:0] MUL  = 32'h022081b3;
  localparam logic [31:0] LW   = 32'h0000a103;
  localparam logic [31:0] BEQ  = 32'h00208063;
  localparam logic [31:0] WFI  = 32'h10500073;

  logic            clock = 1'b0, reset_n = 1'b0, flush = 1'b0, fetch_valid = 1'b0;
  logic [31:0]     fetch_inst = '0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            fetch_ready, dec_valid, dec_halt, dec_illegal, dispatch_valid, halted;
  logic [31:0]     dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic [1:0]      dec_fu, dispatch_fu;
  logic            rob_ready = 1'b0;
  logic [3:0]      rs_ready = '0;
  logic [3:0]      occupancy;
  logic [15:0]     illegal_cnt;

  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  inst_dispatch_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .dec_valid(dec_valid), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_fu(dec_fu), .dec_halt(dec_halt), .dec_illegal(dec_illegal),
    .rob_ready(rob_ready), .rs_ready(rs_ready), .dispatch_valid(dispatch_valid),
    .dispatch_fu(dispatch_fu), .halted(halted), .occupancy(occupancy),
    .illegal_cnt(illegal_cnt)
  );

  // Decoder stand-in: {illegal, halt, fu}
  function automatic logic [3:0] bdec(input logic [31:0] i);
    logic [1:0] fu;
    fu = 2'd0;
    if (i[6:0] == 7'b0110011 && i[31:25] == 7'h01) fu = 2'd3;
    else if (i[6:0] == 7'b0000011 || i[6:0] == 7'b0100011) fu = 2'd1;
    else if (i[6:0] == 7'b1100011) fu = 2'd2;
    return {i[1:0] != 2'b11, i == WFI, fu};
  endfunction

  always_comb {dec_illegal, dec_halt, dec_fu} = bdec(dec_inst);

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } ent_t;

  ent_t mq[$];
  bit   m_halted;
  int   m_ill;
  bit   e_fready, e_dvalid, e_disp, e_pop, e_hgo, e_igo;
  logic [1:0]      e_fu;
  logic [31:0]     e_inst;
  logic [XLEN-1:0] e_pc;

  function automatic void model_eval();
    logic [3:0] d;
    e_fready = !m_halted && mq.size() < DEPTH && !flush;
    e_dvalid = !m_halted && mq.size() > 0 && !flush;
    e_disp = 0; e_pop = 0; e_hgo = 0; e_igo = 0;
    e_fu = '0; e_inst = '0; e_pc = '0;
    if (e_dvalid) begin
      e_inst = mq[0].inst;
      e_pc   = mq[0].pc;
      d      = bdec(e_inst);
      if (d[3]) begin
        e_pop = 1; e_igo = 1;
      end else if (d[2]) begin
        if (rob_ready) begin e_pop = 1; e_disp = 1; e_hgo = 1; end
      end else if (rob_ready && rs_ready[d[1:0]]) begin
        e_pop = 1; e_disp = 1;
      end
      if (e_disp) e_fu = d[1:0];
    end
  endfunction

  task automatic settle();
    @(negedge clock);
    model_eval();
  endtask

  task automatic advance();
    bit pushit;
    pushit = fetch_valid && e_fready;
    if (flush) begin
      mq.delete();
      m_halted = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (pushit) mq.push_back(ent_t'{fetch_inst, fetch_pc});
      if (e_hgo) m_halted = 1;
      if (e_igo && m_ill < 65535) m_ill++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; rob_ready = 1'b0; rs_ready = '0;
    #2;
    mq.delete(); m_halted = 0; m_ill = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL reset_fetch_ready got=%0h exp=1", fetch_ready); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%0h exp=0", dec_valid); end
    checks++; if (dispatch_valid !== 1'b0 || dispatch_fu !== 2'd0) begin failures++; $display("FAIL reset_dispatch got=%0h/%0h exp=0/0", dispatch_valid, dispatch_fu); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0h exp=0", halted); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (illegal_cnt !== 16'd0) begin failures++; $display("FAIL reset_illegal_cnt got=%0d exp=0", illegal_cnt); end
    checks++; if (dec_inst !== 32'd0 || dec_pc !== 32'd0) begin failures++; $display("FAIL reset_dec_fields got=%0h/%0h exp=0/0", dec_inst, dec_pc); end
    advance();
  endtask

  task automatic test_fill();
    rob_ready = 1'b0; rs_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      fetch_valid = 1'b1; fetch_inst = ADDI; fetch_pc = 32'(i * 4);
      settle();
      checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%0h exp=1", i, fetch_ready); end
      checks++; if (occupancy !== 4'(i)) begin failures++; $display("FAIL fill_occ[%0d] got=%0d exp=%0d", i, occupancy, i); end
      advance();
    end
    fetch_pc = 32'h20;
    settle();
    checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%0h exp=0", fetch_ready); end
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL fill_full_occ got=%0d exp=8", occupancy); end
    advance();
    fetch_valid = 1'b0;
    settle();
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL fill_9th_rejected got=%0d exp=8", occupancy); end
    checks++; if (dec_pc !== 32'h0 || dispatch_valid !== 1'b0) begin failures++; $display("FAIL fill_head got=%0h/%0h exp=0/0", dec_pc, dispatch_valid); end
    advance();
  endtask

  task automatic test_drain();
    rob_ready = 1'b1; rs_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++; if (dispatch_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%0h exp=1", i, dispatch_valid); end
      checks++; if (dec_pc !== 32'(i * 4)) begin failures++; $display("FAIL drain_pc[%0d] got=%0h exp=%0h", i, dec_pc, i * 4); end
      checks++; if (dispatch_fu !== 2'd0) begin failures++; $display("FAIL drain_fu[%0d] got=%0d exp=0", i, dispatch_fu); end
      advance();
    end
    settle();
    checks++; if (occupancy !== 4'd0 || dec_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%0h exp=0/0", occupancy, dec_valid); end
    advance();
  endtask

  task automatic test_rs_stall();
    rob_ready = 1'b1; rs_ready = 4'b0111;
    fetch_valid = 1'b1; fetch_inst = MUL; fetch_pc = 32'h40;
    settle();
    advance();
    fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (dispatch_valid !== 1'b0) begin failures++; $display("FAIL rs_stall_valid[%0d] got=%0h exp=0", i, dispatch_valid); end
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h40) begin failures++; $display("FAIL rs_stall_head[%0d] got=%0h/%0h exp=1/40", i, dec_valid, dec_pc); end
      advance();
    end
    rs_ready = 4'hF;
    settle();
    checks++; if (dispatch_valid !== 1'b1 || dispatch_fu !== 2'd3) begin failures++; $display("FAIL rs_release got=%0h/%0d exp=1/3", dispatch_valid, dispatch_fu); end
    advance();
    settle();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL rs_release_occ got=%0d exp=0", occupancy); end
    advance();
  endtask

  task automatic test_illegal();
    int base;
    base = m_ill;
    rob_ready = 1'b0; rs_ready = 4'hF;
    fetch_valid = 1'b1; fetch_inst = 32'h0; fetch_pc = 32'h80;
    settle();
    advance();
    fetch_inst = ADD; fetch_pc = 32'h84;
    settle();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h80 || dispatch_valid !== 1'b0) begin failures++; $display("FAIL illegal_head got=%0h/%0h/%0h exp=1/80/0", dec_valid, dec_pc, dispatch_valid); end
    advance();
    fetch_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (illegal_cnt !== 16'(base + 1)) begin failures++; $display("FAIL illegal_cnt[%0d] got=%0d exp=%0d", i, illegal_cnt, base + 1); end
      checks++; if (dec_pc !== 32'h84 || dispatch_valid !== 1'b0 || occupancy !== 4'd1) begin failures++; $display("FAIL illegal_next got=%0h/%0h/%0d exp=84/0/1", dec_pc, dispatch_valid, occupancy); end
      advance();
    end
    rob_ready = 1'b1;
    settle();
    checks++; if (dispatch_valid !== 1'b1 || dispatch_fu !== 2'd0) begin failures++; $display("FAIL illegal_add_disp got=%0h/%0d exp=1/0", dispatch_valid, dispatch_fu); end
    advance();
  endtask

  task automatic test_halt();
    rob_ready = 1'b1; rs_ready = 4'hF;
    fetch_valid = 1'b1; fetch_inst = ADD; fetch_pc = 32'h100;
    settle();
    advance();
    fetch_inst = WFI; fetch_pc = 32'h104;
    settle();
    checks++; if (dispatch_valid !== 1'b1 || dec_pc !== 32'h100) begin failures++; $display("FAIL halt_add1 got=%0h/%0h exp=1/100", dispatch_valid, dec_pc); end
    advance();
    fetch_inst = ADD; fetch_pc = 32'h108;
    settle();
    checks++; if (dispatch_valid !== 1'b1 || dec_pc !== 32'h104 || halted !== 1'b0) begin failures++; $display("FAIL halt_wfi got=%0h/%0h/%0h exp=1/104/0", dispatch_valid, dec_pc, halted); end
    advance();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (halted !== 1'b1 || fetch_ready !== 1'b0) begin failures++; $display("FAIL halt_state[%0d] got=%0h/%0h exp=1/0", i, halted, fetch_ready); end
      checks++; if (dispatch_valid !== 1'b0 || dec_valid !== 1'b0 || occupancy !== 4'd1) begin failures++; $display("FAIL halt_hold[%0d] got=%0h/%0h/%0d exp=0/0/1", i, dispatch_valid, dec_valid, occupancy); end
      advance();
    end
    flush = 1'b1; fetch_valid = 1'b0;
    settle();
    checks++; if (dispatch_valid !== 1'b0) begin failures++; $display("FAIL halt_flush_disp got=%0h exp=0", dispatch_valid); end
    advance();
    flush = 1'b0;
    settle();
    checks++; if (halted !== 1'b0 || occupancy !== 4'd0 || fetch_ready !== 1'b1) begin failures++; $display("FAIL halt_recover got=%0h/%0d/%0h exp=0/0/1", halted, occupancy, fetch_ready); end
    advance();
  endtask

  task automatic test_flush_wrap();
    rob_ready = 1'b0; rs_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1; fetch_inst = ADDI; fetch_pc = 32'(32'h200 + i * 4);
      settle(); advance();
    end
    fetch_valid = 1'b0; rob_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++; if (dispatch_valid !== 1'b1 || dec_pc !== 32'(32'h200 + i * 4)) begin failures++; $display("FAIL wrap_drain[%0d] got=%0h/%0h exp=1/%0h", i, dispatch_valid, dec_pc, 32'h200 + i * 4); end
      advance();
    end
    rob_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1; fetch_inst = ADDI; fetch_pc = 32'(32'h300 + i * 4);
      settle(); advance();
    end
    fetch_valid = 1'b0;
    settle();
    checks++; if (occupancy !== 4'd5 || dec_pc !== 32'h214) begin failures++; $display("FAIL wrap_occ got=%0d/%0h exp=5/214", occupancy, dec_pc); end
    advance();
    flush = 1'b1; fetch_valid = 1'b1; rob_ready = 1'b1; fetch_pc = 32'h400;
    settle();
    checks++; if (fetch_ready !== 1'b0 || dispatch_valid !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("FAIL wrap_flush_cycle got=%0h/%0h/%0h exp=0/0/0", fetch_ready, dispatch_valid, dec_valid); end
    advance();
    flush = 1'b0; fetch_valid = 1'b0;
    settle();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL wrap_flush_occ got=%0d exp=0", occupancy); end
    checks++; if (illegal_cnt !== 16'd1) begin failures++; $display("FAIL wrap_flush_illegal got=%0d exp=1", illegal_cnt); end
    advance();
    fetch_valid = 1'b1; fetch_inst = ADD; fetch_pc = 32'h500;
    settle(); advance();
    fetch_valid = 1'b0;
    settle();
    checks++; if (dispatch_valid !== 1'b1 || dec_pc !== 32'h500 || dec_inst !== ADD) begin failures++; $display("FAIL wrap_new_push got=%0h/%0h/%0h exp=1/500/%0h", dispatch_valid, dec_pc, dec_inst, ADD); end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] tbl [5];
    int idx;
    tbl[0] = ADDI; tbl[1] = ADD; tbl[2] = MUL; tbl[3] = LW; tbl[4] = BEQ;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      idx = $urandom_range(0, 19);
      if (idx == 0) fetch_inst = WFI;
      else if (idx <= 2) fetch_inst = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      else fetch_inst = tbl[idx % 5];
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_pc    = $urandom;
      rob_ready   = ($urandom_range(0, 3) != 0);
      rs_ready    = 4'($urandom);
      flush       = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      settle();
      checks++; if (fetch_ready !== e_fready) begin failures++; $display("FAIL rnd_fetch_ready[%0d] got=%0h exp=%0h", n, fetch_ready, e_fready); end
      checks++; if (dec_valid !== e_dvalid) begin failures++; $display("FAIL rnd_dec_valid[%0d] got=%0h exp=%0h", n, dec_valid, e_dvalid); end
      checks++; if (dispatch_valid !== e_disp) begin failures++; $display("FAIL rnd_dispatch[%0d] got=%0h exp=%0h", n, dispatch_valid, e_disp); end
      checks++; if (dispatch_fu !== e_fu) begin failures++; $display("FAIL rnd_fu[%0d] got=%0d exp=%0d", n, dispatch_fu, e_fu); end
      checks++; if (halted !== m_halted) begin failures++; $display("FAIL rnd_halted[%0d] got=%0h exp=%0h", n, halted, m_halted); end
      checks++; if (occupancy !== 4'(mq.size())) begin failures++; $display("FAIL rnd_occ[%0d] got=%0d exp=%0d", n, occupancy, mq.size()); end
      checks++; if (illegal_cnt !== 16'(m_ill)) begin failures++; $display("FAIL rnd_illegal[%0d] got=%0d exp=%0d", n, illegal_cnt, m_ill); end
      if (e_dvalid) begin
        checks++; if (dec_pc !== e_pc || dec_inst !== e_inst) begin failures++; $display("FAIL rnd_head[%0d] got=%0h/%0h exp=%0h/%0h", n, dec_pc, dec_inst, e_pc, e_inst); end
      end
      advance();
    end
    flush = 1'b0; fetch_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_rs_stall();
    test_illegal();
    test_halt();
    test_flush_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
